rgb565_packer: RTL and testbench
================================

RGB565_PACKER -- requirements
Module: rgb565_packer

Interface
REQ-001 Parameter H_RES, default 320, active pixels per line; SHALL be even and at least 2.
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output FIFO depth in 32-bit words; SHALL be a power of 2 and at least 8.
REQ-004 i_sysclk  in  1  single clock; all logic is on its rising edge.
REQ-005 i_arst  in  1  reset; synchronous and active-high (fixed, see Reset).
REQ-006 i_R, i_G, i_B  in  8 each  RGB888 pixel from the colour-conversion stage.
REQ-007 i_valid  in  1  pixel qualifier; delayed by the upstream stage to match its fixed latency.
REQ-008 i_sof  in  1  start-of-frame; sampled only when i_valid=1; marks pixel (0,0).
REQ-009 o_data  out  32  packed word: even-x pixel in [15:0], odd-x pixel in [31:16]; each pixel is R[15:11] G[10:5] B[4:0].
REQ-010 o_valid  out  1  o_data holds a valid word.
REQ-011 i_ready  in  1  downstream accepts the word.
REQ-012 o_eof  out  1  qualifies o_data; the current word is the last word of the frame.
REQ-013 o_afull  out  1  FIFO almost full; the upstream decoder SHALL stall on it.
REQ-014 o_overflow  out  1  sticky; at least one word was dropped.
REQ-015 o_sync_err  out  1  sticky; i_sof arrived while x!=0 or y!=0.

Function
REQ-016 Position counters x (0..H_RES-1) and y (0..V_RES-1):
- both advance on each i_valid;
- x wraps at H_RES-1 and y increments on the wrap;
- y wraps at V_RES-1 after x wraps.
REQ-017 i_sof with i_valid SHALL force this pixel to (0,0) and discard any half-packed word.
REQ-018 Dither uses a 2x2 Bayer matrix indexed by {y[0],x[0]}: (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1.
REQ-019 R5 and B5 are the top 5 bits of min(C + 2*bayer, 255).
REQ-020 G6 is the top 6 bits of min(G + bayer, 255).
REQ-021 Pipeline stage 1 SHALL register the dithered RGB565 pixel, its x[0], and an end-of-frame flag (x=H_RES-1 and y=V_RES-1).
REQ-022 Pipeline stage 2 SHALL hold the even pixel and, on the odd pixel, write one word plus its eof bit into the FIFO.
REQ-023 Latency SHALL be fixed: with the FIFO empty, odd pixel sampled at cycle N gives o_valid=1 at N+3.
REQ-024 FIFO handshake: a word transfers when o_valid and i_ready are both 1; o_data and o_eof SHALL hold stable while o_valid=1 and i_ready=0.
REQ-025 o_afull=1 when occupancy is at least FIFO_DEPTH-4.
REQ-026 A write while full with no simultaneous read SHALL drop the new word, keep the FIFO contents, and set o_overflow.
REQ-027 A read and a write in the same cycle while full SHALL both succeed, with occupancy unchanged.
REQ-028 Read and write in the same cycle while empty: o_valid rises the next cycle; the word is not bypassed.
REQ-029 No input ready exists; pixels are never stalled inside the pipeline.

Reset
REQ-030 While i_arst=1 at a clock edge:
- x, y, the half-word register, the FIFO pointers and occupancy, and both sticky flags clear;
- o_valid, o_eof, o_afull, o_overflow and o_sync_err are 0;
- o_data is 0.
REQ-031 Reset mid-line or mid-frame SHALL discard all in-flight pixels and words; the first pixel after reset is (0,0).

Structure
REQ-032 A shared package SHALL hold the Bayer matrix, RGB565 field positions, and word/pixel width constants.
REQ-033 The FIFO SHALL be one sub-module, pixel_fifo (synchronous, width 33, depth FIFO_DEPTH, registered output, occupancy output).
REQ-034 Target size is 120-400 RTL lines; no multipliers and no RAM other than the FIFO.

Verification
REQ-035 Pixel (0,0) = (255,255,255) followed by (1,0) = (0,0,0), i_ready=1 -> o_data=0x0000FFFF at N+3.
REQ-036 Pixel (1,0) = (6,1,6), i.e. bayer 2 -> R5=1, G6=0, B5=1, so the high half of the word is 0x0801.
REQ-037 H_RES=4, V_RES=2, stream 8 pixels with i_ready=1 -> exactly 4 words, o_eof=1 on the 4th word only.
REQ-038 i_ready=0 and continuous pixels -> o_afull rises at occupancy 12; on the 17th word o_overflow rises and the FIFO contents are unchanged.
REQ-039 i_sof at x=3 -> o_sync_err=1, the pending half-word is discarded, and the next word contains pixels (0,0) and (1,0).
REQ-040 i_arst for 1 cycle at mid-frame with a FIFO of 5 words -> all outputs 0 next cycle; a subsequent frame produces correct words.

Source files
------------

// File: rtl/rgb565_packer_pkg.sv
// Shared constants for the RGB565 packer: pixel/word widths, RGB565 field layout,
// the 2x2 Bayer dither matrix and the per-channel dither/pack helpers.
package rgb565_packer_pkg;

  localparam int CHAN_W = 8;
  localparam int PIX_W  = 16;
  localparam int WORD_W = 2 * PIX_W;
  localparam int FIFO_W = WORD_W + 1;

  localparam int R_LSB = 11;
  localparam int R_W   = 5;
  localparam int G_LSB = 5;
  localparam int G_W   = 6;
  localparam int B_LSB = 0;
  localparam int B_W   = 5;

  // Entry {y[0],x[0]} lives at bits [2*idx +: 2]: (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1.
  localparam logic [7:0] BAYER_TBL = {2'd1, 2'd3, 2'd2, 2'd0};

  function automatic logic [1:0] bayer_at(input logic y0, input logic x0);
    return BAYER_TBL[{y0, x0, 1'b0} +: 2];
  endfunction

  function automatic logic [CHAN_W-1:0] sat_add(input logic [CHAN_W-1:0] c,
                                                input logic [2:0]        d);
    logic [CHAN_W:0] sum;
    sum = {1'b0, c} + {{(CHAN_W-2){1'b0}}, d};
    return sum[CHAN_W] ? {CHAN_W{1'b1}} : sum[CHAN_W-1:0];
  endfunction

  function automatic logic [PIX_W-1:0] pack565(input logic [CHAN_W-1:0] r,
                                               input logic [CHAN_W-1:0] g,
                                               input logic [CHAN_W-1:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_LSB +: R_W] = r[CHAN_W-1 -: R_W];
    p[G_LSB +: G_W] = g[CHAN_W-1 -: G_W];
    p[B_LSB +: B_W] = b[CHAN_W-1 -: B_W];
    return p;
  endfunction

endpackage

// File: rtl/rgb565_packer_pixel_fifo.sv
// Synchronous FIFO with a registered head: a word written at edge E is visible after E+1;
// a write when full with no pop is dropped (o_drop pulses) and contents are kept.
module pixel_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_vld,
  input  logic [WIDTH-1:0]         i_wr_dat,
  output logic                     o_rd_vld,
  output logic [WIDTH-1:0]         o_rd_dat,
  input  logic                     i_rd_rdy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_vld;
  logic [WIDTH-1:0] r_dat;

  logic             w_pop;
  logic             w_full;
  logic             w_wr_ok;
  logic [AW-1:0]    w_rd_ptr_nxt;
  logic [CW-1:0]    w_left;

  always_comb begin
    w_pop        = r_vld & i_rd_rdy;
    w_full       = (r_count == CW'(DEPTH));
    w_wr_ok      = i_wr_vld & (~w_full | w_pop);
    w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
    w_left       = r_count - CW'(w_pop);
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  // The head register only reloads from entries present before this edge, so a fresh
  // write into an empty FIFO is never bypassed to the output.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_vld    <= 1'b0;
      r_dat    <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_left + CW'(w_wr_ok);
      r_vld    <= (w_left != '0);
      r_dat    <= (w_left != '0) ? r_mem[w_rd_ptr_nxt] : '0;
    end
  end

  assign o_rd_vld = r_vld;
  assign o_rd_dat = r_dat;
  assign o_count  = r_count;
  assign o_drop   = i_wr_vld & w_full & ~w_pop;

endmodule

// File: rtl/rgb565_packer.sv
// Dithers RGB888 pixels to RGB565 and packs pixel pairs into 32-bit words; odd pixel at
// edge N gives o_valid after edge N+3. No input stall: a full FIFO drops words (sticky flag).
module rgb565_packer
  import rgb565_packer_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_sysclk,
  input  logic              i_arst,
  input  logic [CHAN_W-1:0] i_R,
  input  logic [CHAN_W-1:0] i_G,
  input  logic [CHAN_W-1:0] i_B,
  input  logic              i_valid,
  input  logic              i_sof,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_eof,
  output logic              o_afull,
  output logic              o_overflow,
  output logic              o_sync_err
);

  localparam int X_W = $clog2(H_RES);
  localparam int Y_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [X_W-1:0]    r_x;
  logic [Y_W-1:0]    r_y;
  logic              r_sync_err;
  logic              r_overflow;

  logic              r_s1_vld;
  logic [PIX_W-1:0]  r_s1_pix;
  logic              r_s1_odd;
  logic              r_s1_eof;

  logic              r_half_vld;
  logic [PIX_W-1:0]  r_half;
  logic              r_wr_vld;
  logic [FIFO_W-1:0] r_wr_dat;

  logic [X_W-1:0]    w_x;
  logic [Y_W-1:0]    w_y;
  logic              w_x_last;
  logic              w_y_last;
  logic [1:0]        w_bayer;
  logic [PIX_W-1:0]  w_pix;
  logic              w_rd_vld;
  logic [FIFO_W-1:0] w_rd_dat;
  logic [CW-1:0]     w_count;
  logic              w_drop;

  // A start-of-frame pixel is placed at (0,0) regardless of where the counters were.
  always_comb begin
    w_x      = i_sof ? '0 : r_x;
    w_y      = i_sof ? '0 : r_y;
    w_x_last = (w_x == X_W'(H_RES - 1));
    w_y_last = (w_y == Y_W'(V_RES - 1));
    w_bayer  = bayer_at(w_y[0], w_x[0]);
    w_pix    = pack565(sat_add(i_R, {w_bayer, 1'b0}),
                       sat_add(i_G, {1'b0, w_bayer}),
                       sat_add(i_B, {w_bayer, 1'b0}));
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_x        <= '0;
      r_y        <= '0;
      r_sync_err <= 1'b0;
    end else if (i_valid) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= w_y_last ? '0 : w_y + Y_W'(1);
      end else begin
        r_x <= w_x + X_W'(1);
        r_y <= w_y;
      end
      if (i_sof && ((r_x != '0) || (r_y != '0))) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_s1_vld <= 1'b0;
      r_s1_pix <= '0;
      r_s1_odd <= 1'b0;
      r_s1_eof <= 1'b0;
    end else begin
      r_s1_vld <= i_valid;
      r_s1_pix <= w_pix;
      r_s1_odd <= w_x[0];
      r_s1_eof <= w_x_last & w_y_last;
    end
  end

  // An even pixel always replaces the held half-word, which is how a mid-line
  // start-of-frame discards the stale half; an odd pixel with no partner is dropped.
  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_half_vld <= 1'b0;
      r_half     <= '0;
      r_wr_vld   <= 1'b0;
      r_wr_dat   <= '0;
    end else begin
      r_wr_vld <= 1'b0;
      if (r_s1_vld) begin
        if (!r_s1_odd) begin
          r_half     <= r_s1_pix;
          r_half_vld <= 1'b1;
        end else if (r_half_vld) begin
          r_wr_vld   <= 1'b1;
          r_wr_dat   <= {r_s1_eof, r_s1_pix, r_half};
          r_half_vld <= 1'b0;
        end
      end
    end
  end

  pixel_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pixel_fifo (
    .i_clk    (i_sysclk),
    .i_rst    (i_arst),
    .i_wr_vld (r_wr_vld),
    .i_wr_dat (r_wr_dat),
    .o_rd_vld (w_rd_vld),
    .o_rd_dat (w_rd_dat),
    .i_rd_rdy (i_ready),
    .o_count  (w_count),
    .o_drop   (w_drop)
  );

  always_ff @(posedge i_sysclk) begin
    if (i_arst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_valid    = w_rd_vld;
  assign o_data     = w_rd_dat[WORD_W-1:0];
  assign o_eof      = w_rd_dat[WORD_W];
  assign o_afull    = (w_count >= CW'(FIFO_DEPTH - 4));
  assign o_overflow = r_overflow;
  assign o_sync_err = r_sync_err;

endmodule

// File: tb/tb_rgb565_packer.sv
// Scoreboard bench for rgb565_packer with a 4x2 frame and a 16-word FIFO.
module tb_rgb565_packer;

  logic        i_sysclk;
  logic        i_arst;
  logic [7:0]  i_R, i_G, i_B;
  logic        i_valid, i_sof, i_ready;
  logic [31:0] o_data;
  logic        o_valid, o_eof, o_afull, o_overflow, o_sync_err;

  rgb565_packer #(
    .H_RES      (4),
    .V_RES      (2),
    .FIFO_DEPTH (16)
  ) dut (
    .i_sysclk   (i_sysclk),
    .i_arst     (i_arst),
    .i_R        (i_R),
    .i_G        (i_G),
    .i_B        (i_B),
    .i_valid    (i_valid),
    .i_sof      (i_sof),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_eof      (o_eof),
    .o_afull    (o_afull),
    .o_overflow (o_overflow),
    .o_sync_err (o_sync_err)
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  logic [32:0] exp_q[$];
  int          total;
  int          bad;
  int          popped;
  int          base;
  logic [23:0] fr_pix [8];
  logic [32:0] fr_word [4];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"},    33'(o_valid),    33'd0);
    chk({tag, "_data"},     33'(o_data),     33'd0);
    chk({tag, "_eof"},      33'(o_eof),      33'd0);
    chk({tag, "_afull"},    33'(o_afull),    33'd0);
    chk({tag, "_overflow"}, 33'(o_overflow), 33'd0);
    chk({tag, "_sync_err"}, 33'(o_sync_err), 33'd0);
  endtask

  task automatic pix(input logic [23:0] rgb, input logic sof);
    i_R     = rgb[23:16];
    i_G     = rgb[15:8];
    i_B     = rgb[7:0];
    i_valid = 1'b1;
    i_sof   = sof;
    @(posedge i_sysclk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_sysclk);
    #1;
  endtask

  task automatic send_frame(input int first, input int last, input logic sof0);
    for (int i = first; i <= last; i++) begin
      if (i % 2 == 0) exp_q.push_back(fr_word[i/2]);
      pix(fr_pix[i], sof0 && (i == 0));
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge i_sysclk);
      #1;
      n++;
    end
    chk(name, 33'(exp_q.size()), 33'd0);
  endtask

  function automatic logic [15:0] exp565(input logic [4:0] k);
    return {k, k, 1'b0, k};
  endfunction

  initial begin
    fr_pix[0] = 24'hFFFFFF;  fr_pix[1] = 24'h000000;
    fr_pix[2] = 24'h6432C8;  fr_pix[3] = 24'h060106;
    fr_pix[4] = 24'hFAFE03;  fr_pix[5] = 24'h080410;
    fr_pix[6] = 24'h0700FF;  fr_pix[7] = 24'hFFFD00;
    fr_word[0] = {1'b0, 32'h0000FFFF};
    fr_word[1] = {1'b0, 32'h08016199};
    fr_word[2] = {1'b0, 32'h0822FFE1};
    fr_word[3] = {1'b1, 32'hFFE0081F};
    total = 0; bad = 0; popped = 0; base = 0;
    i_arst = 1'b1; i_ready = 1'b0; i_valid = 1'b0; i_sof = 1'b0;
    i_R = 8'h00; i_G = 8'h00; i_B = 8'h00;

    fork
      forever begin
        @(negedge i_sysclk);
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_word: got %0h expected no word", {o_eof, o_data});
          end else begin
            chk("word", {o_eof, o_data}, exp_q.pop_front());
            popped++;
          end
        end
      end
    join_none

    repeat (3) @(posedge i_sysclk);
    #1;
    check_zero("rst");
    i_arst  = 1'b0;
    i_ready = 1'b1;

    // Latency: odd pixel sampled at edge N, word visible after edge N+3.
    exp_q.push_back(fr_word[0]);
    pix(fr_pix[0], 1'b1);
    pix(fr_pix[1], 1'b0);
    idle(1); chk("lat_n1", 33'(o_valid), 33'd0);
    idle(1); chk("lat_n2", 33'(o_valid), 33'd0);
    idle(1); chk("lat_n3", 33'(o_valid), 33'd1);
    chk("lat_data", {o_eof, o_data}, fr_word[0]);
    send_frame(2, 7, 1'b0);

    // Frame wrap without sof, then a mid-line sof at x=3.
    exp_q.push_back({1'b0, 32'h000008A3});
    pix(24'h0A141E, 1'b0);
    pix(24'h000000, 1'b0);
    pix(24'h000000, 1'b0);
    idle(4);
    chk("sync_clean", 33'(o_sync_err), 33'd0);
    exp_q.push_back({1'b0, 32'h0000FFFF});
    pix(24'hFFFFFF, 1'b1);
    pix(24'h000000, 1'b0);
    wait_drain("drain1", 40);
    chk("words1", 33'(popped), 33'd6);
    chk("sync_err_set", 33'(o_sync_err), 33'd1);

    // Fill the FIFO with i_ready low: afull at 12 words, 17th word dropped.
    i_arst = 1'b1;
    idle(1);
    i_arst = 1'b0;
    chk("rst2_sync", 33'(o_sync_err), 33'd0);
    i_ready = 1'b0;
    base = popped;
    for (int w = 0; w < 17; w++) begin
      logic [4:0] ke;
      logic [4:0] ko;
      ke = 5'(2 * w);
      ko = 5'(2 * w + 1);
      if (w < 16) exp_q.push_back({(w % 4 == 3), exp565(ko), exp565(ke)});
      pix({3{ke, 3'b000}}, 1'b0);
      pix({3{ko, 3'b000}}, 1'b0);
      if (w == 10) begin
        idle(4);
        chk("afull_11", 33'(o_afull), 33'd0);
      end
      if (w == 11) begin
        idle(4);
        chk("afull_12", 33'(o_afull), 33'd1);
      end
      if (w == 15) begin
        idle(4);
        chk("ovf_16", 33'(o_overflow), 33'd0);
        chk("hold_head", 33'(o_data), 33'h08410000);
      end
      if (w == 16) begin
        idle(4);
        chk("ovf_17", 33'(o_overflow), 33'd1);
        chk("head_kept", 33'(o_data), 33'h08410000);
      end
    end
    i_ready = 1'b1;
    wait_drain("drain2", 80);
    chk("words2", 33'(popped - base), 33'd16);
    idle(5);
    chk("no_dropped_word", 33'(o_valid), 33'd0);
    chk("afull_clear", 33'(o_afull), 33'd0);

    // Mid-frame reset with 5 words queued and a pixel arriving on the reset edge.
    i_ready = 1'b0;
    pix(24'h404040, 1'b1);
    for (int i = 0; i < 10; i++) pix(24'h505050, 1'b0);
    idle(4);
    chk("pre_rst_valid", 33'(o_valid), 33'd1);
    chk("pre_rst_sync", 33'(o_sync_err), 33'd1);
    chk("pre_rst_ovf", 33'(o_overflow), 33'd1);
    i_R = 8'h11; i_G = 8'h22; i_B = 8'h33;
    i_valid = 1'b1;
    i_arst  = 1'b1;
    @(posedge i_sysclk);
    #1;
    i_arst  = 1'b0;
    i_valid = 1'b0;
    check_zero("rst3");
    i_ready = 1'b1;
    idle(6);
    chk("rst3_flushed", 33'(o_valid), 33'd0);
    base = popped;
    send_frame(0, 7, 1'b0);
    wait_drain("drain3", 40);
    chk("words3", 33'(popped - base), 33'd4);
    chk("sync_after_rst", 33'(o_sync_err), 33'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
